// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed N-digit 7-segment display scanner.
//
// Scans NUM_DIG digits. Each digit gets a slot of CLK_DIV clocks. The hex nibble
// of the selected digit is decoded to segments, with an optional decimal point.
// Digits can be masked, leading zeros can be suppressed, and digits can blink.
// The displayed data comes from a frame snapshot, so the digits of one frame never
// mix old and new data.
//
// Optional build macro: SEG_SCAN_GUARD_EN
//   When defined, DIG is held all-inactive for the first GUARD_CYC clocks of every
//   slot. This blanking interval keeps ghosting off the next digit. SEG already
//   carries the new pattern during this interval.
//   When undefined, DIG stays active for the whole slot and GUARD_CYC is ignored.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   en           scan enable; low = display dark, counters cleared, snapshot tracks inputs
//   digits       4*NUM_DIG nibbles, nibble k = digit k (k=0 rightmost)
//   dp_in        decimal point per digit, 1 = lit
//   dig_mask     1 = digit shown, 0 = blanked (its slot is still scanned)
//   blink_mask   1 = digit blinks
//   lz_suppress  1 = blank leading zeros (digit 0 always shown)
//   DIG          digit selects, one-hot active, polarity per DIG_ACTIVE_LOW
//   SEG          {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   frame_tick   1-cycle pulse after the last slot of each frame

module seg_scan_ctrl #(
  parameter int NUM_DIG        = 8,
  parameter int CLK_DIV        = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int GUARD_CYC      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [4*NUM_DIG-1:0]   digits,
  input  logic [NUM_DIG-1:0]     dp_in,
  input  logic [NUM_DIG-1:0]     dig_mask,
  input  logic [NUM_DIG-1:0]     blink_mask,
  input  logic                   lz_suppress,
  output logic [NUM_DIG-1:0]     DIG,
  output logic [7:0]             SEG,
  output logic                   frame_tick
);

  localparam int IW = $clog2(NUM_DIG);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIG - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

  // XOR masks that turn the active-high internal patterns into pin levels.
  localparam logic [NUM_DIG-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
  localparam logic [7:0]         SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

`ifdef SEG_SCAN_GUARD_EN
  localparam int GUARD_LEN = (GUARD_CYC < CLK_DIV) ? GUARD_CYC : CLK_DIV - 1;
`else
  localparam int GUARD_LEN = 0 * GUARD_CYC;
`endif

  logic [PW-1:0]        pcnt;
  logic [IW-1:0]        idx;
  logic [BW-1:0]        bcnt;
  logic                 blink_phase;
  logic [4*NUM_DIG-1:0] snap_dig;
  logic [NUM_DIG-1:0]   snap_dp;

  logic slot_tick;
  logic frame_end;

  assign slot_tick = (pcnt == PCNT_LAST);
  assign frame_end = slot_tick && (idx == IDX_LAST);

  // Scan counters, blink timebase and frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt        <= '0;
      idx         <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b1;
      snap_dig    <= '0;
      snap_dp     <= '0;
      frame_tick  <= 1'b0;
    end else if (!en) begin
      pcnt        <= '0;
      idx         <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b1;
      snap_dig    <= digits;
      snap_dp     <= dp_in;
      frame_tick  <= 1'b0;
    end else begin
      pcnt       <= slot_tick ? '0 : pcnt + 1'b1;
      frame_tick <= frame_end;
      if (slot_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        snap_dig <= digits;
        snap_dp  <= dp_in;
        if (bcnt == BCNT_LAST) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h27;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h67;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // lz_vec[k] = snapshot nibbles k..NUM_DIG-1 are all zero.
  logic [NUM_DIG-1:0] lz_vec;
  logic               lz_run;

  always_comb begin
    lz_vec = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      lz_run    = lz_run && (snap_dig[4*k +: 4] == 4'h0);
      lz_vec[k] = lz_run;
    end
  end

  logic                 guard;
  logic [3:0]           nib;
  logic                 lz_blank;
  logic                 hard_blank;
  logic [NUM_DIG-1:0]   dig_nxt;
  logic [7:0]           seg_nxt;

  assign guard = (GUARD_LEN > 0) ? (pcnt < PW'(GUARD_LEN)) : 1'b0;

  always_comb begin
    dig_nxt    = '0;
    seg_nxt    = '0;
    nib        = snap_dig[{idx, 2'b00} +: 4];
    lz_blank   = lz_suppress && lz_vec[idx] && (idx != '0);
    hard_blank = !dig_mask[idx] || (blink_mask[idx] && !blink_phase);

    if (!guard) begin
      dig_nxt[idx] = 1'b1;
    end

    seg_nxt = {snap_dp[idx], hex7(nib)};
    // A suppressed leading zero still shows its decimal point.
    if (lz_blank) begin
      seg_nxt[6:0] = 7'h00;
    end
    if (hard_blank) begin
      seg_nxt = 8'h00;
    end
  end

  // Pin registers: one clock behind idx, so the pins change only on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DIG <= DIG_POL;
      SEG <= SEG_POL;
    end else if (!en) begin
      DIG <= DIG_POL;
      SEG <= SEG_POL;
    end else begin
      DIG <= dig_nxt ^ DIG_POL;
      SEG <= seg_nxt ^ SEG_POL;
    end
  end

endmodule
